// File: rtl/pwm_sequencer_if.sv
// -----------------------------------------------------------------------------
// pwm_sequencer_if
// Bundles the control, table-write and compare-output signals of the PWM step
// sequencer.  Signal prefixes are from the sequencer's point of view:
//   i_* : driven by the register file / PWM counter (master) into the sequencer
//   o_* : driven by the sequencer (slave) towards the PWM compare inputs
// Modports:
//   master : register-file / PWM side
//   slave  : sequencer side
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface pwm_sequencer_if #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned REPEAT_WIDTH = 8
);
    localparam int unsigned STEP_BITS = $clog2(DEPTH);

    logic                      i_start;
    logic                      i_stop;
    logic                      i_loop;
    logic [STEP_BITS-1:0]      i_length;
    logic [REPEAT_WIDTH-1:0]   i_repeat;
    logic [CHANNELS-1:0]       i_channel_mask;
    logic                      i_period_end;
    logic                      i_table_we;
    logic [STEP_BITS-1:0]      i_table_address;
    logic [WIDTH-1:0]          i_table_data;
    logic [CHANNELS*WIDTH-1:0] o_compare_value;
    logic [CHANNELS-1:0]       o_compare_update;
    logic                      o_busy;
    logic                      o_done;
    logic [STEP_BITS-1:0]      o_step_index;

    modport master (
        output i_start, i_stop, i_loop, i_length, i_repeat, i_channel_mask,
               i_period_end, i_table_we, i_table_address, i_table_data,
        input  o_compare_value, o_compare_update, o_busy, o_done, o_step_index
    );

    modport slave (
        input  i_start, i_stop, i_loop, i_length, i_repeat, i_channel_mask,
               i_period_end, i_table_we, i_table_address, i_table_data,
        output o_compare_value, o_compare_update, o_busy, o_done, o_step_index
    );
endinterface

// File: rtl/pwm_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_sequencer
// Steps the per-channel PWM compare values through a DEPTH-entry table.  Each
// entry is held for repeat+1 PWM periods; changes happen only on the clock
// edge that samples period_end, so compare values switch at period boundaries.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : pwm_sequencer_if.slave (start/stop/config, table write port,
//          compare_value/compare_update outputs, busy/done/step_index)
// Build option:
//   PWM_SEQ_PHASE_EN : channel i loads entry (step_index + i) mod DEPTH
//                      instead of entry step_index.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pwm_sequencer #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned REPEAT_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    pwm_sequencer_if.slave bus
);
    localparam int unsigned STEP_BITS = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;

    logic [WIDTH-1:0]                r_table [DEPTH];
    logic                            r_cfg_loop;
    logic [STEP_BITS-1:0]            r_cfg_length;
    logic [REPEAT_WIDTH-1:0]         r_cfg_repeat;
    logic [CHANNELS-1:0]             r_cfg_mask;
    logic [REPEAT_WIDTH-1:0]         r_rpt_cnt;
    logic [STEP_BITS-1:0]            r_step;
    logic [CHANNELS-1:0][WIDTH-1:0]  r_compare;
    logic [CHANNELS-1:0]             r_update;
    logic                            r_done;

    logic                            w_accept_start;
    logic                            w_load;
    logic                            w_done;
    logic [STEP_BITS-1:0]            w_step_next;
    logic [REPEAT_WIDTH-1:0]         w_cnt_next;
    logic [CHANNELS-1:0][STEP_BITS-1:0] w_entry_idx;

    // Next-state / step control.  r_rpt_cnt counts the periods still to hold
    // the current entry after its load pulse.  done fires on the last held
    // period of the last step, so a non-looping run takes exactly
    // (length+1)*(repeat+1) period_end pulses.
    always_comb begin
        w_state_next   = r_state;
        w_accept_start = 1'b0;
        w_load         = 1'b0;
        w_done         = 1'b0;
        w_step_next    = r_step;
        w_cnt_next     = r_rpt_cnt;

        if (bus.i_stop) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        w_accept_start = 1'b1;
                        w_state_next   = S_ARM;
                        w_step_next    = '0;
                    end
                end
                S_ARM, S_RUN: begin
                    if (bus.i_period_end) begin
                        if (r_state == S_RUN && r_rpt_cnt != '0) begin
                            w_cnt_next = r_rpt_cnt - 1'b1;
                            if (r_rpt_cnt == REPEAT_WIDTH'(1) &&
                                r_step == r_cfg_length && !r_cfg_loop) begin
                                w_done = 1'b1;
                            end
                        end else begin
                            w_load     = 1'b1;
                            w_cnt_next = r_cfg_repeat;
                            if (r_state == S_RUN && r_step < r_cfg_length) begin
                                w_step_next = r_step + 1'b1;
                            end else begin
                                w_step_next = '0;
                            end
                            w_state_next = S_RUN;
                            if (r_cfg_repeat == '0 && w_step_next == r_cfg_length &&
                                !r_cfg_loop) begin
                                w_done = 1'b1;
                            end
                        end
                        if (w_done) begin
                            w_state_next = S_IDLE;
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Table entry loaded by each channel for the step being entered.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
`ifdef PWM_SEQ_PHASE_EN
            w_entry_idx[i] = w_step_next + STEP_BITS'(i);
`else
            w_entry_idx[i] = w_step_next;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_table[k] <= '0;
            end
        end else if (bus.i_table_we) begin
            r_table[bus.i_table_address] <= bus.i_table_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_loop   <= 1'b0;
            r_cfg_length <= '0;
            r_cfg_repeat <= '0;
            r_cfg_mask   <= '0;
            r_rpt_cnt    <= '0;
            r_step       <= '0;
            r_compare    <= '0;
            r_update     <= '0;
            r_done       <= 1'b0;
        end else begin
            r_step    <= w_step_next;
            r_rpt_cnt <= w_cnt_next;
            r_done    <= w_done;
            if (w_accept_start) begin
                r_cfg_loop   <= bus.i_loop;
                r_cfg_length <= bus.i_length;
                r_cfg_repeat <= bus.i_repeat;
                r_cfg_mask   <= bus.i_channel_mask;
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (w_load && r_cfg_mask[i]) begin
                    r_compare[i] <= r_table[w_entry_idx[i]];
                    r_update[i]  <= 1'b1;
                end else begin
                    r_update[i]  <= 1'b0;
                end
            end
        end
    end

    assign bus.o_compare_value  = r_compare;
    assign bus.o_compare_update = r_update;
    assign bus.o_busy           = (r_state != S_IDLE);
    assign bus.o_done           = r_done;
    assign bus.o_step_index     = r_step;
endmodule

// File: doc/pwm_sequencer.md
Name: pwm_sequencer

Overview:
Step sequencer that drives the compare values of a multi-channel PWM block from a small on-chip table, so fades and pulse patterns run without CPU writes every period. Each table entry is held for a programmable number of PWM periods and advances on the PWM period-end pulse, so compare changes land only at period boundaries. The block sits between the peripheral-bus register file, which supplies the table writes and control, and the per-channel compare inputs of the PWM outputs.

Parameters:
CHANNELS, 4, number of PWM channels driven
WIDTH, 16, compare value width in bits
DEPTH, 16, table entries; power of two, at least 2; STEP_BITS = $clog2(DEPTH)
REPEAT_WIDTH, 8, width of the per-step period repeat count

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle start pulse
stop  in  1  single-cycle stop pulse
loop  in  1  wrap to entry 0 after the last step instead of finishing
length  in  STEP_BITS  index of the last step (0 means one step)
repeat  in  REPEAT_WIDTH  each step is held for repeat+1 periods
channel_mask  in  CHANNELS  channels the sequencer drives
period_end  in  1  single-cycle pulse at PWM counter wrap
table_we  in  1  table write strobe
table_address  in  STEP_BITS  table write index
table_data  in  WIDTH  table write value
compare_value  out  CHANNELS*WIDTH  per-channel compare value; channel i occupies bits [i*WIDTH +: WIDTH]
compare_update  out  CHANNELS  one-cycle pulse when a channel's compare_value changes register
busy  out  1  sequence armed or running
done  out  1  one-cycle pulse at sequence completion
step_index  out  STEP_BITS  current step

Behaviour:
- Reset (rst low, asynchronous): state IDLE; compare_value, compare_update, busy, done and step_index all 0; all table entries 0.
- Table: DEPTH x WIDTH register array with one write port. A write lands on the clk edge where table_we is high and is allowed in any state. Reads are combinational. A write to the entry being loaded in the same cycle returns the old value.
- Config latch: loop, length, repeat and channel_mask are captured on an accepted start. They are ignored at all other times.
- FSM:
  - IDLE: busy=0. start -> ARM; step_index<=0.
  - ARM: busy=1. Wait for period_end. On period_end: load step 0 into the masked channels, load the repeat counter with repeat, go to RUN.
  - RUN: busy=1. On period_end with repeat counter nonzero: decrement the counter.
    - On period_end with counter 0 and step_index < length: step_index+1, load that entry, reload the counter.
    - On period_end with counter 0 and step_index == length and loop=1: step_index<=0, load entry 0, reload the counter.
    - On period_end with counter 0 and step_index == length and loop=0: go to IDLE, pulse done for one cycle, busy=0 the following cycle.
- Load: for each masked channel, compare_value is written on the clk edge that samples period_end, and compare_update[i] is high for that one following cycle. Unmasked channels are never written and keep their value.
- stop: from any state, next state is IDLE with no done pulse. compare_value and step_index are retained.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- start and period_end in the same cycle in IDLE: go to ARM only; the first load waits for the next period_end.
- period_end while IDLE is ignored.
- repeat=0: a new step on every period_end. repeat=255 (REPEAT_WIDTH=8): 256 periods per step.
- Total periods per non-looping run = (length+1)*(repeat+1), counted from the first period_end after start; done asserts on the clock edge that samples the final period_end.

Optional Feature:
PWM_SEQ_PHASE_EN. When defined, channel i loads entry (step_index + i) mod DEPTH, with the sum truncated to STEP_BITS, giving phase-shifted multi-channel patterns. When undefined, every masked channel loads entry[step_index]. All other behaviour is identical.

Test Plan:
- Reset then idle: hold rst low, pulse period_end x3 -> compare_value=0, busy=0, done=0, no compare_update.
- Basic run: table={100,200,300}, length=2, repeat=1, mask=4'b0001, loop=0, start, then 6 period_end pulses -> ch0 sequence 100,100,200,200,300,300; done on the 6th pulse; busy drops the next cycle; ch1-3 stay 0.
- Loop and stop: same table, loop=1, repeat=0, mask=4'b1111 -> values 100,200,300,100; stop before the 5th period_end -> IDLE, no done, all channels hold 100.
- Collisions: start+stop same cycle -> stays IDLE. start during RUN -> ignored, step_index continues. Write to table entry 1 during step 0 -> the new value appears at step 1.
- Boundary: length=DEPTH-1=15, repeat=0, loop=1 -> step_index wraps 15->0 with no done; repeat=8'hFF with length=0, loop=0 -> done after exactly 256 period_end pulses.
- PWM_SEQ_PHASE_EN: table[k]=k*10, mask=4'b1111, step 15 -> ch0..ch3 = 150, 0, 10, 20.
